// File: rtl/ycbcr444_to_422.sv
// YCbCr 4:4:4 to 4:2:2 converter for a vid_io stream.
// Data and timing leave through two register stages, so the latency is a fixed 2 clk.
module ycbcr444_to_422 #(
    parameter logic CB_FIRST  = 1'b1,
    parameter logic FILTER_EN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        vid_io_in_active_video,
    input  logic [23:0] vid_io_in_data,
    input  logic        vid_io_in_field,
    input  logic        vid_io_in_hblank,
    input  logic        vid_io_in_hsync,
    input  logic        vid_io_in_vblank,
    input  logic        vid_io_in_vsync,
    input  logic        bypass,
    input  logic        odd_clr,
    output logic        vid_io_out_active_video,
    output logic [23:0] vid_io_out_data,
    output logic        vid_io_out_field,
    output logic        vid_io_out_hblank,
    output logic        vid_io_out_hsync,
    output logic        vid_io_out_vblank,
    output logic        vid_io_out_vsync,
    output logic        bypass_active,
    output logic        odd_line_err
);

    function automatic logic [7:0] avg_round(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[8:1];
    endfunction

    logic        vld_p1;
    logic        odd_p1;
    logic [23:0] data_p1;
    logic        field_p1, hblank_p1, hsync_p1, vblank_p1, vsync_p1;
    logic [7:0]  c_hold;

    logic        cur_odd, partner, last_even, vsync_rise;
    logic [7:0]  cb_e, cr_e, cb_o, cr_o;
    logic [7:0]  avg_cb, avg_cr, c_first, c_second, c_own, c_sel;
    logic [23:0] data_nxt;

    always_comb begin
        // The input pixel continues the line only if stage 1 holds an active pixel.
        cur_odd    = vld_p1 ? ~odd_p1 : 1'b0;
        partner    = vld_p1 & ~odd_p1 & vid_io_in_active_video;
        last_even  = vld_p1 & ~odd_p1 & ~vid_io_in_active_video;
        vsync_rise = vid_io_in_vsync & ~vsync_p1;

        cb_e = data_p1[15:8];
        cr_e = data_p1[23:16];
        cb_o = vid_io_in_data[15:8];
        cr_o = vid_io_in_data[23:16];

        avg_cb   = FILTER_EN ? avg_round(cb_e, cb_o) : cb_e;
        avg_cr   = FILTER_EN ? avg_round(cr_e, cr_o) : cr_e;
        c_first  = CB_FIRST ? avg_cb : avg_cr;
        c_second = CB_FIRST ? avg_cr : avg_cb;
        c_own    = CB_FIRST ? cb_e : cr_e;

        if (odd_p1)
            c_sel = c_hold;
        else if (partner)
            c_sel = c_first;
        else
            c_sel = c_own;

        if (!vld_p1)
            data_nxt = '0;
        else if (bypass_active)
            data_nxt = data_p1;
        else
            data_nxt = {8'h00, c_sel, data_p1[7:0]};
    end

    // Stage 1: capture the input pixel, its timing and its phase within the line
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1    <= 1'b0;
            odd_p1    <= 1'b0;
            data_p1   <= '0;
            field_p1  <= 1'b0;
            hblank_p1 <= 1'b0;
            hsync_p1  <= 1'b0;
            vblank_p1 <= 1'b0;
            vsync_p1  <= 1'b0;
        end else begin
            vld_p1    <= vid_io_in_active_video;
            odd_p1    <= vid_io_in_active_video ? cur_odd : 1'b0;
            data_p1   <= vid_io_in_data;
            field_p1  <= vid_io_in_field;
            hblank_p1 <= vid_io_in_hblank;
            hsync_p1  <= vid_io_in_hsync;
            vblank_p1 <= vid_io_in_vblank;
            vsync_p1  <= vid_io_in_vsync;
        end
    end

    // Stage 2: output register, chroma hold for the odd pixel, mode and error flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vid_io_out_active_video <= 1'b0;
            vid_io_out_data         <= '0;
            vid_io_out_field        <= 1'b0;
            vid_io_out_hblank       <= 1'b0;
            vid_io_out_hsync        <= 1'b0;
            vid_io_out_vblank       <= 1'b0;
            vid_io_out_vsync        <= 1'b0;
            c_hold                  <= '0;
            bypass_active           <= 1'b0;
            odd_line_err            <= 1'b0;
        end else begin
            vid_io_out_active_video <= vld_p1;
            vid_io_out_data         <= data_nxt;
            vid_io_out_field        <= field_p1;
            vid_io_out_hblank       <= hblank_p1;
            vid_io_out_hsync        <= hsync_p1;
            vid_io_out_vblank       <= vblank_p1;
            vid_io_out_vsync        <= vsync_p1;
            if (partner)
                c_hold <= c_second;
            if (vsync_rise)
                bypass_active <= bypass;
            if (odd_clr)
                odd_line_err <= 1'b0;
            else if (last_even)
                odd_line_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ycbcr444_to_422.sv
// Bench for ycbcr444_to_422: three parameter variants share one stimulus stream,
// compared against a line-level reference model, plus directed reset checks.
module tb_ycbcr444_to_422;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, av, field, hb, hs, vb, vs, bypass, odd_clr;
    logic [23:0] din;

    logic        o_av [3];
    logic [23:0] o_data [3];
    logic        o_field [3], o_hb [3], o_hs [3], o_vb [3], o_vs [3];
    logic        o_byp [3], o_err [3];

    ycbcr444_to_422 #(.CB_FIRST(1'b1), .FILTER_EN(1'b1)) u0 (
        .clk(clk), .resetn(resetn), .vid_io_in_active_video(av), .vid_io_in_data(din),
        .vid_io_in_field(field), .vid_io_in_hblank(hb), .vid_io_in_hsync(hs),
        .vid_io_in_vblank(vb), .vid_io_in_vsync(vs), .bypass(bypass), .odd_clr(odd_clr),
        .vid_io_out_active_video(o_av[0]), .vid_io_out_data(o_data[0]),
        .vid_io_out_field(o_field[0]), .vid_io_out_hblank(o_hb[0]), .vid_io_out_hsync(o_hs[0]),
        .vid_io_out_vblank(o_vb[0]), .vid_io_out_vsync(o_vs[0]),
        .bypass_active(o_byp[0]), .odd_line_err(o_err[0]));

    ycbcr444_to_422 #(.CB_FIRST(1'b1), .FILTER_EN(1'b0)) u1 (
        .clk(clk), .resetn(resetn), .vid_io_in_active_video(av), .vid_io_in_data(din),
        .vid_io_in_field(field), .vid_io_in_hblank(hb), .vid_io_in_hsync(hs),
        .vid_io_in_vblank(vb), .vid_io_in_vsync(vs), .bypass(bypass), .odd_clr(odd_clr),
        .vid_io_out_active_video(o_av[1]), .vid_io_out_data(o_data[1]),
        .vid_io_out_field(o_field[1]), .vid_io_out_hblank(o_hb[1]), .vid_io_out_hsync(o_hs[1]),
        .vid_io_out_vblank(o_vb[1]), .vid_io_out_vsync(o_vs[1]),
        .bypass_active(o_byp[1]), .odd_line_err(o_err[1]));

    ycbcr444_to_422 #(.CB_FIRST(1'b0), .FILTER_EN(1'b1)) u2 (
        .clk(clk), .resetn(resetn), .vid_io_in_active_video(av), .vid_io_in_data(din),
        .vid_io_in_field(field), .vid_io_in_hblank(hb), .vid_io_in_hsync(hs),
        .vid_io_in_vblank(vb), .vid_io_in_vsync(vs), .bypass(bypass), .odd_clr(odd_clr),
        .vid_io_out_active_video(o_av[2]), .vid_io_out_data(o_data[2]),
        .vid_io_out_field(o_field[2]), .vid_io_out_hblank(o_hb[2]), .vid_io_out_hsync(o_hs[2]),
        .vid_io_out_vblank(o_vb[2]), .vid_io_out_vsync(o_vs[2]),
        .bypass_active(o_byp[2]), .odd_line_err(o_err[2]));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stimulus stream, one entry per clock
    logic        q_av[$], q_fld[$], q_hb[$], q_hs[$], q_vb[$], q_vs[$], q_byp[$], q_clr[$];
    logic [23:0] q_data[$];
    int          q_chk[$];
    logic        md[$];
    logic        cur_byp = 1'b0, cur_clr = 1'b0, cur_fld = 1'b0;

    task automatic push(input logic a, input logic [23:0] d, input logic h, input logic hsy,
                        input logic v, input logic vsy, input int ck);
        q_av.push_back(a);   q_data.push_back(d); q_hb.push_back(h);   q_hs.push_back(hsy);
        q_vb.push_back(v);   q_vs.push_back(vsy); q_fld.push_back(cur_fld);
        q_byp.push_back(cur_byp); q_clr.push_back(cur_clr); q_chk.push_back(ck);
    endtask

    task automatic px(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        push(1'b1, {cr, cb, y}, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic blank(input int nb, input logic v, input logic hsy, input int ck);
        for (int k = 0; k < nb; k++) push(1'b0, 24'h0, 1'b1, hsy, v, 1'b0, ck);
    endtask

    task automatic hgap();
        blank(2, 1'b0, 1'b0, -1); blank(2, 1'b0, 1'b1, -1); blank(2, 1'b0, 1'b0, -1);
    endtask

    task automatic vgap();
        blank(2, 1'b1, 1'b0, -1);
        for (int k = 0; k < 2; k++) push(1'b0, 24'h0, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        blank(2, 1'b1, 1'b0, -1);
        cur_fld = ~cur_fld;
    endtask

    task automatic clr_pulse();
        cur_clr = 1'b1; blank(1, 1'b0, 1'b0, -1); cur_clr = 1'b0;
    endtask

    task automatic rand_line(input int len);
        for (int k = 0; k < len; k++)
            px(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        hgap();
    endtask

    function automatic logic [7:0] mix(input logic [7:0] e, input logic [7:0] o, input logic flt);
        int s;
        s = (int'(e) + int'(o) + 1) / 2;
        return flt ? 8'(s) : e;
    endfunction

    // Reference: pixels are paired by their position counted from the start of each line
    function automatic logic [23:0] model(input int j, input logic cbf, input logic flt);
        int s, e;
        logic [7:0] c;
        if (!q_av[j]) return 24'h0;
        if (md[j]) return q_data[j];
        s = j;
        while (s > 0 && q_av[s-1]) s--;
        if ((j - s) % 2 == 0) begin
            if (j + 1 < q_av.size() && q_av[j+1]) begin
                e = j;
                c = cbf ? mix(q_data[e][15:8], q_data[e+1][15:8], flt)
                        : mix(q_data[e][23:16], q_data[e+1][23:16], flt);
            end else begin
                c = cbf ? q_data[j][15:8] : q_data[j][23:16];
            end
        end else begin
            e = j - 1;
            c = cbf ? mix(q_data[e][23:16], q_data[j][23:16], flt)
                    : mix(q_data[e][15:8], q_data[j][15:8], flt);
        end
        return {8'h00, c, q_data[j][7:0]};
    endfunction

    task automatic apply(input int i);
        av = q_av[i]; din = q_data[i]; field = q_fld[i]; hb = q_hb[i]; hs = q_hs[i];
        vb = q_vb[i]; vs = q_vs[i]; bypass = q_byp[i]; odd_clr = q_clr[i];
    endtask

    task automatic idle();
        av = 1'b0; din = 24'h0; hb = 1'b1; hs = 1'b0; vb = 1'b0; vs = 1'b0; odd_clr = 1'b0;
    endtask

    logic        cfg_cbf [3];
    logic        cfg_flt [3];
    logic [15:0] k0 [4], k1 [4], k2 [4];

    initial begin
        int n, p4, m_last;
        logic m;

        cfg_cbf = '{1'b1, 1'b1, 1'b0};
        cfg_flt = '{1'b1, 1'b0, 1'b1};
        k0 = '{16'h650A, 16'hC914, 16'h331E, 16'h3D28};
        k1 = '{16'h640A, 16'hC814, 16'h321E, 16'h3C28};
        k2 = '{16'hC90A, 16'h6514, 16'h3D1E, 16'h3328};

        // Build the stimulus stream
        vgap();
        p4 = q_av.size();
        px(10, 100, 200); px(20, 102, 201); px(30, 50, 60); px(40, 51, 61); hgap();
        px(1, 255, 254); px(2, 255, 255); px(3, 0, 7); px(4, 1, 9); hgap();
        blank(1, 1'b0, 1'b0, 0);
        px(5, 10, 40); px(6, 20, 50); px(7, 30, 60);
        blank(3, 1'b0, 1'b0, -1); blank(1, 1'b0, 1'b0, 1); clr_pulse(); blank(1, 1'b0, 1'b0, 0);
        px(8, 77, 88);
        hgap(); blank(1, 1'b0, 1'b0, 1); clr_pulse(); blank(1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 4; k++) rand_line($urandom_range(1, 12));
        for (int k = 0; k < 3; k++)
            px(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        cur_byp = 1'b1;
        rand_line(3);
        rand_line(6);
        vgap();
        rand_line(5); rand_line(8);
        for (int k = 0; k < 2; k++)
            px(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        cur_byp = 1'b0;
        rand_line(4);
        rand_line(7);
        vgap();
        rand_line(6); rand_line(9);
        blank(4, 1'b0, 1'b0, -1);

        n = q_av.size();
        m = 1'b0;
        for (int j = 0; j < n; j++) begin
            if (q_vs[j] && (j == 0 || !q_vs[j-1])) m = q_byp[j];
            md.push_back(m);
        end

        // Reset state
        resetn = 1'b0; bypass = 1'b0; field = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_av", 32'(o_av[0]), 32'd0);
        chk("rst_data", 32'(o_data[0]), 32'd0);
        chk("rst_byp", 32'(o_byp[0]), 32'd0);
        chk("rst_err", 32'(o_err[0]), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Streaming run: after the edge that captures input i, outputs show pixel i-1
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) apply(i); else idle();
            @(posedge clk);
            #1;
            if (i >= 1 && i - 1 < n) begin
                int j;
                j = i - 1;
                chk("av_lag", 32'(o_av[0]), 32'(q_av[j]));
                chk("field_lag", 32'(o_field[0]), 32'(q_fld[j]));
                chk("hblank_lag", 32'(o_hb[0]), 32'(q_hb[j]));
                chk("hsync_lag", 32'(o_hs[0]), 32'(q_hs[j]));
                chk("vblank_lag", 32'(o_vb[0]), 32'(q_vb[j]));
                chk("vsync_lag", 32'(o_vs[0]), 32'(q_vs[j]));
                for (int c = 0; c < 3; c++)
                    chk($sformatf("data_cfg%0d_px%0d", c, j), 32'(o_data[c]),
                        32'(model(j, cfg_cbf[c], cfg_flt[c])));
                if (j >= p4 && j < p4 + 4) begin
                    chk("known_line_cfg0", 32'(o_data[0]), 32'(k0[j-p4]));
                    chk("known_line_cfg1", 32'(o_data[1]), 32'(k1[j-p4]));
                    chk("known_line_cfg2", 32'(o_data[2]), 32'(k2[j-p4]));
                end
            end
            m_last = (i < n) ? i : n - 1;
            chk("bypass_active", 32'(o_byp[0]), 32'(md[m_last]));
            if (i < n && q_chk[i] >= 0)
                chk("odd_line_err", 32'(o_err[0]), 32'(q_chk[i]));
        end

        // Mid-line reset: outputs clear at once, next line starts on Cb
        for (int k = 0; k < 3; k++) begin
            av = 1'b1; hb = 1'b0; din = {8'(k + 90), 8'(k + 30), 8'(k + 1)};
            @(posedge clk);
            #1;
        end
        chk("pre_reset_av", 32'(o_av[0]), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("reset_av", 32'(o_av[0]), 32'd0);
        chk("reset_data", 32'(o_data[0]), 32'd0);
        chk("reset_hblank", 32'(o_hb[0]), 32'd0);
        chk("reset_err", 32'(o_err[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
        end
        idle();
        repeat (3) @(posedge clk);
        #1;
        av = 1'b1; hb = 1'b0; din = {8'd90, 8'd40, 8'h21};
        @(posedge clk);
        #1;
        din = {8'd110, 8'd60, 8'h22};
        @(posedge clk);
        #1;
        chk("post_reset_e_cfg0", 32'(o_data[0]), 32'h00_32_21);
        chk("post_reset_e_cfg1", 32'(o_data[1]), 32'h00_28_21);
        chk("post_reset_e_cfg2", 32'(o_data[2]), 32'h00_64_21);
        idle();
        @(posedge clk);
        #1;
        chk("post_reset_o_cfg0", 32'(o_data[0]), 32'h00_64_22);
        chk("post_reset_o_cfg1", 32'(o_data[1]), 32'h00_5A_22);
        chk("post_reset_o_cfg2", 32'(o_data[2]), 32'h00_32_22);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
